plot_sink: RTL
==============

# plot_sink

Receiving end of the datapath pixel stream (`plot`, `x`, `y`, `color`). It buffers incoming pixels in a small FIFO and writes them into an on-chip 320x240x3 framebuffer. It provides a hardware fill command for full-screen clears and a pipelined readback port that game logic uses for colour-based collision checks (frog on river object vs water). It sits between the `datapath` plot outputs and the display memory.

## Interface
- `RES_X`, 320, framebuffer width in pixels
- `RES_Y`, 240, framebuffer height in pixels
- `ADDR_WIDTH`, 17, framebuffer address width (must satisfy 2^ADDR_WIDTH >= RES_X*RES_Y)
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of two)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `plot`  in  1  pixel strobe; sampled every rising edge, no backpressure
- `x`  in  9  pixel column
- `y`  in  9  pixel row
- `color`  in  3  pixel colour {R,G,B}
- `clear`  in  1  one-cycle fill request
- `clear_color`  in  3  fill colour, sampled with `clear`
- `clear_done`  out  1  one-cycle pulse when the fill completes
- `busy`  out  1  high while in CLEAR or while the FIFO is non-empty
- `rd_req`  in  1  readback request
- `rd_x`  in  9  readback column
- `rd_y`  in  9  readback row
- `rd_valid`  out  1  readback result strobe
- `rd_color`  out  3  readback colour
- `drop_count`  out  8  saturating count of discarded pixels

## Operation
- Address = y*RES_X + x. For the default width, computed as (y<<8)+(y<<6)+x in ADDR_WIDTH bits. No multiplier.
- Input stage: when `plot`=1 and x<RES_X and y<RES_Y, push {addr,color} into the FIFO. Out-of-range pixels are discarded and `drop_count`++.
- FIFO full with a push pending: discard the pixel and increment `drop_count`. `drop_count` saturates at 255.
- FSM has two states.
  - S_IDLE: if the FIFO is non-empty, pop the head and write it to RAM, one pixel per cycle. `clear`=1 latches `clear_color`, zeroes the fill counter and goes to S_CLEAR. The FIFO pop is suppressed that cycle.
  - S_CLEAR: each cycle, write the latched colour at the fill counter address, then increment the counter. The FIFO keeps accepting pushes but is not drained. When the counter reaches RES_X*RES_Y-1 and that write is done, pulse `clear_done` and return to S_IDLE.
- `clear` asserted while in S_CLEAR is ignored (no restart, no second `clear_done`).
- Simultaneous push and pop on a full FIFO: the push succeeds and there is no drop.
- Readback: a one-cycle pipeline, independent of the FSM, with one request accepted per cycle.
  - Out-of-range `rd_x`/`rd_y` returns `rd_color`=0 with `rd_valid` still asserted.
  - A read and a write to the same address in the same cycle returns the old data.
- Reset at any point:
  - FSM goes to S_IDLE, the fill counter clears, the FIFO empties, and `drop_count` clears.
  - The readback pipeline flushes (`rd_valid`=0).
  - RAM contents are not cleared.

## Timing
- Output reset values: `clear_done`=0, `busy`=0, `rd_valid`=0, `rd_color`=0, `drop_count`=0.
- Pixel write latency, FIFO empty, S_IDLE: `plot` sampled at edge N, RAM written at edge N+1.
- Fill: `clear` sampled at edge N, first write at edge N+1, last write at edge N+RES_X*RES_Y. `clear_done` is high for the cycle after that edge.
- Readback: `rd_req` at edge N gives `rd_valid`/`rd_color` valid after edge N+2, held for one cycle. Back-to-back requests give back-to-back results.
- `busy` is registered and reflects the state and FIFO count after each edge.

## Structure
- Shared package constants:
  - `RES_X`, `RES_Y`
  - colour width 3
  - FSM state encodings `S_IDLE`, `S_CLEAR`
  - the address function
- Sub-module `framebuffer_ram`: simple dual-port RAM (one write port, one registered read port), RES_X*RES_Y x 3, inferred as M9K.
- The FIFO stays inline: registered array with head/tail pointers and a count.

## Test plan
- Reset, then `plot` x=5 y=2 color=3'b100. Read back x=5 y=2 and get `rd_color`=3'b100 two cycles after the request.
- `clear` with `clear_color`=3'b001: `busy` stays high for 76800 cycles and `clear_done` pulses once. Reading (0,0), (319,239) and (160,120) all returns 3'b001.
- Start a clear, then stream 20 pixels: 16 are buffered and 4 are dropped (`drop_count`=4). The 16 buffered pixels land after `clear_done`, in order, and read back correctly.
- `plot` at x=320 y=0 and at x=0 y=240: `drop_count`=2 and RAM is unchanged (read (0,0) returns its prior value).
- Assert `reset` mid-clear at counter 1000: `busy`=0 the next cycle, no `clear_done` pulse, and a new `clear` completes normally.
- Three back-to-back `rd_req` to (1,1), (2,2), out-of-range (400,0): three consecutive `rd_valid` cycles with the stored colours, then 0.

Source files
------------

// File: rtl/plot_sink_pkg.sv
// Shared constants, FSM encoding and the pixel address function for plot_sink.
package plot_sink_pkg;

    localparam int RES_X   = 320;
    localparam int RES_Y   = 240;
    localparam int COLOR_W = 3;
    localparam int COORD_W = 9;
    localparam int ADDR_W  = 17;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // y*res_x + x built from shifted copies of y, one per set bit of the
    // constant width; for 320 this reduces to (y<<8)+(y<<6)+x.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input int                 res_x);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int i = 0; i < ADDR_W; i++) begin
            if (res_x[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Pixel stream, fill command and readback port of plot_sink.
//
// Signalling: every input is a plain strobe sampled on each rising clk edge;
// there is no ready/backpressure anywhere. plot qualifies x/y/color, clear
// qualifies clear_color, rd_req qualifies rd_x/rd_y. Results come back as
// single-cycle strobes (clear_done, rd_valid qualifying rd_color).
interface plot_sink_if;
    import plot_sink_pkg::*;

    logic               plot;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               clear;
    logic [COLOR_W-1:0] clear_color;
    logic               clear_done;
    logic               busy;
    logic               rd_req;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               rd_valid;
    logic [COLOR_W-1:0] rd_color;
    logic [7:0]         drop_count;
    state_t             state;       // debug view of the write FSM

    modport master (
        output plot, x, y, color, clear, clear_color, rd_req, rd_x, rd_y,
        input  clear_done, busy, rd_valid, rd_color, drop_count, state
    );

    modport slave (
        input  plot, x, y, color, clear, clear_color, rd_req, rd_x, rd_y,
        output clear_done, busy, rd_valid, rd_color, drop_count, state
    );

endinterface

// File: rtl/plot_sink_framebuffer_ram.sv
// Simple dual-port framebuffer: one write port, one registered read port.
// A read and write to the same address on one edge returns the old data.
module framebuffer_ram #(
    parameter int DEPTH = 76800,
    parameter int AW    = 17,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/plot_sink.sv
// Pixel sink: FIFO-buffered pixel writes, full-screen fill, pipelined readback.
module plot_sink #(
    parameter int RES_X      = 320,
    parameter int RES_Y      = 240,
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 16
) (
    input logic        clk,
    input logic        reset,
    plot_sink_if.slave bus
);
    import plot_sink_pkg::*;

    localparam int                    NPIX      = RES_X * RES_Y;
    localparam int                    PW        = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam logic [PW:0]           FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [COLOR_W-1:0]    color;
    } entry_t;

    entry_t                fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         head, tail;
    logic [PW:0]           count, count_next;
    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [COLOR_W-1:0]    fill_color;
    logic [7:0]            drop_cnt;
    logic                  clear_done_r, busy_r;
    logic                  pop, push, drop, start_clear, fill_we, done_now;
    logic                  in_range, rd_in_range;
    logic [ADDR_WIDTH-1:0] wr_addr_in, rd_addr_in;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [COLOR_W-1:0]    ram_wdata, ram_q;
    logic                  rq_v, rq_in, v2, in2, rd_valid_r;
    logic [ADDR_WIDTH-1:0] rq_addr;
    logic [COLOR_W-1:0]    rd_color_r;

    assign in_range    = (bus.x < COORD_W'(RES_X)) && (bus.y < COORD_W'(RES_Y));
    assign rd_in_range = (bus.rd_x < COORD_W'(RES_X)) && (bus.rd_y < COORD_W'(RES_Y));
    assign wr_addr_in  = ADDR_WIDTH'(pix_addr(bus.x, bus.y, RES_X));
    assign rd_addr_in  = ADDR_WIDTH'(pix_addr(bus.rd_x, bus.rd_y, RES_X));

    // Next state, FIFO pop and fill control; a clear request wins over a pop.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        start_clear = 1'b0;
        fill_we     = 1'b0;
        done_now    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.clear) begin
                    start_clear = 1'b1;
                    state_next  = S_CLEAR;
                end else if (count != '0) begin
                    pop = 1'b1;
                end
            end
            S_CLEAR: begin
                fill_we = 1'b1;
                if (fill_cnt == LAST_ADDR) begin
                    done_now   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        push       = bus.plot && in_range && ((count != FULL_CNT) || pop);
        drop       = bus.plot && !push;
        count_next = count + (PW + 1)'(push) - (PW + 1)'(pop);
    end

    // RAM write port is shared between FIFO drain and fill; never both at once.
    always_comb begin
        ram_we    = pop || fill_we;
        ram_waddr = fill_cnt;
        ram_wdata = fill_color;
        if (pop) begin
            ram_waddr = fifo_mem[head].addr;
            ram_wdata = fifo_mem[head].color;
        end
    end

    // FSM state, fill counter/colour, done pulse and registered busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            fill_cnt     <= '0;
            fill_color   <= '0;
            clear_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state        <= state_next;
            clear_done_r <= done_now;
            busy_r       <= (state_next == S_CLEAR) || (count_next != '0);
            if (start_clear) begin
                fill_cnt   <= '0;
                fill_color <= bus.clear_color;
            end else if (fill_we) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= '{addr: wr_addr_in, color: bus.color};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count_next;
        end
    end

    // Saturating count of discarded pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Readback: capture request, RAM read, then output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rq_v       <= 1'b0;
            rq_in      <= 1'b0;
            rq_addr    <= '0;
            v2         <= 1'b0;
            in2        <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_color_r <= '0;
        end else begin
            rq_v       <= bus.rd_req;
            rq_in      <= rd_in_range;
            rq_addr    <= rd_in_range ? rd_addr_in : '0;
            v2         <= rq_v;
            in2        <= rq_in;
            rd_valid_r <= v2;
            rd_color_r <= (v2 && in2) ? ram_q : '0;
        end
    end

    framebuffer_ram #(
        .DEPTH (NPIX),
        .AW    (ADDR_WIDTH),
        .DW    (COLOR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rq_addr),
        .rdata (ram_q)
    );

    assign bus.clear_done = clear_done_r;
    assign bus.busy       = busy_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_color   = rd_color_r;
    assign bus.drop_count = drop_cnt;
    assign bus.state      = state;

endmodule
